sdram_wr_buf: RTL

- Upstream feeder for the SDRAM write engine.
- Buffers a user word stream in an internal FIFO.
- When a full burst of words is available, issues a one-cycle write trigger with burst length and linear SDRAM address.
- Serves words to the write engine, which pops them with wr_data_en; the burst address advances after each completed burst.

---
 rtl/sdram_wr_buf.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sdram_wr_buf.sv
// sdram_wr_buf: write-side buffer in front of the SDRAM write engine.
// Collects user words in a first-word-fall-through FIFO. Once a full burst is
// buffered it raises a one-cycle wr_trig carrying the burst length and the
// linear SDRAM address. The engine then drains the words with wr_data_en.
// The address advances after every completed burst and wraps at END_ADDR.
// Optional feature macro: SDRAM_WR_BUF_FLUSH_EN adds a flush input that
// issues a partial burst of whatever is buffered.

module sdram_wr_buf #(
    parameter int unsigned       DW        = 16,
    parameter int unsigned       AW        = 5,
    parameter int unsigned       BURST_LEN = 4,
    parameter int unsigned       ADDR_W    = 20,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR  = '1
) (
    input  logic              sclk,
    input  logic              srst_n,
    input  logic [DW-1:0]     din,
    input  logic              din_vld,
`ifdef SDRAM_WR_BUF_FLUSH_EN
    input  logic              flush,
`endif
    output logic              wr_trig,
    output logic [AW:0]       wr_len,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DW-1:0]     wr_data,
    input  logic              wr_data_en,
    output logic [AW:0]       fifo_cnt,
    output logic              busy,
    output logic              ovf,
    output logic              udf
);

    localparam int unsigned Depth     = 2 ** AW;
    localparam logic [AW:0] DepthW    = Depth[AW:0];
    localparam logic [AW:0] BurstLenW = BURST_LEN[AW:0];

    typedef enum logic [1:0] {StIdle, StTrig, StBurst} state_e;

    logic [DW-1:0]     mem_q [Depth];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       cnt_q, cnt_d;
    logic              push, pop;
    logic              ovf_q, udf_q;

    state_e            state_q, state_d;
    logic [AW:0]       len_q, len_d;
    logic [AW:0]       bcnt_q, bcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   addr_sum;

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    always_comb begin
        pop  = wr_data_en && (cnt_q != '0);
        push = din_vld && ((cnt_q < DepthW) || pop);
    end

    // Occupancy next-state: simultaneous push and pop leaves it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    // Storage array; contents need no reset because the pointers and count do.
    always_ff @(posedge sclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers, count and sticky error flags.
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_d;
            if (din_vld && !push) begin
                ovf_q <= 1'b1;
            end
            if (wr_data_en && (cnt_q == '0)) begin
                udf_q <= 1'b1;
            end
        end
    end

    // Next burst address, computed one bit wider so the wrap test never truncates.
    always_comb begin
        addr_sum = {1'b0, addr_q} + {{(ADDR_W-AW){1'b0}}, len_q};
    end

    // Burst sequencing: trigger, count pops, then advance the address.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        bcnt_d  = bcnt_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                if (cnt_q >= BurstLenW) begin
                    state_d = StTrig;
                    len_d   = BurstLenW;
                end
`ifdef SDRAM_WR_BUF_FLUSH_EN
                else if (flush && (cnt_q != '0)) begin
                    state_d = StTrig;
                    len_d   = cnt_q;
                end
`endif
            end
            StTrig: begin
                state_d = StBurst;
            end
            StBurst: begin
                if (pop) begin
                    if (bcnt_q + (AW+1)'(1) == len_q) begin
                        state_d = StIdle;
                        bcnt_d  = '0;
                        if (addr_sum > {1'b0, END_ADDR}) begin
                            addr_d = BASE_ADDR;
                        end else begin
                            addr_d = addr_sum[ADDR_W-1:0];
                        end
                    end else begin
                        bcnt_d = bcnt_q + (AW+1)'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM and burst registers.
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state_q <= StIdle;
            len_q   <= '0;
            bcnt_q  <= '0;
            addr_q  <= BASE_ADDR;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            bcnt_q  <= bcnt_d;
            addr_q  <= addr_d;
        end
    end

    // Outputs; the head word is forced to zero while the FIFO is empty.
    always_comb begin
        wr_trig  = (state_q == StTrig);
        busy     = (state_q != StIdle);
        wr_len   = len_q;
        wr_addr  = addr_q;
        fifo_cnt = cnt_q;
        ovf      = ovf_q;
        udf      = udf_q;
        wr_data  = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
    end

endmodule
